// File: rtl/lane_queue_counter_if.sv
// lane_queue_counter_if: lane bus between the sensor/light side and the
// lane queue counter.
//   master : drives arrive, green, clear; observes the count outputs
//   slave  : the counter itself
// Signals:
//   arrive      per-lane car arrival
//   green       per-lane green light (from trafficLightOutput)
//   clear       synchronous clear of counts and overflow flags
//   laneCounts  packed counts, lane i at [i*CNT_W +: CNT_W]
//   busiestLane index of the fullest lane
//   anyWaiting  any lane non-empty
//   overflow    sticky per-lane dropped-arrival flags
interface lane_queue_counter_if #(
    parameter int NUM_LANES = 8,
    parameter int CNT_W     = 8
);
    logic [NUM_LANES-1:0]       arrive;
    logic [NUM_LANES-1:0]       green;
    logic                       clear;
    logic [NUM_LANES*CNT_W-1:0] laneCounts;
    logic [2:0]                 busiestLane;
    logic                       anyWaiting;
    logic [NUM_LANES-1:0]       overflow;

    modport master (
        output arrive, green, clear,
        input  laneCounts, busiestLane, anyWaiting, overflow
    );

    modport slave (
        input  arrive, green, clear,
        output laneCounts, busiestLane, anyWaiting, overflow
    );
endinterface

// File: rtl/lane_queue_counter.sv
// lane_queue_counter: per-lane waiting-car counters feeding the Breadboard
// intersection controller's packed 8x8-bit lane bus {w1,w2,s1,s2,e1,e2,n1,n2}.
// Counts rise on arrivals and fall by one per departure tick on green lanes.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  lane_queue_counter_if.slave (arrive, green, clear in;
//        laneCounts, busiestLane, anyWaiting, overflow out)
// Optional build macro LANE_QUEUE_DEBOUNCE_EN: arrive is a raw sensor level,
// synchronised (2 flops) and edge-detected so a held sensor counts one car.

// One lane's saturating up/down counter with sticky overflow.
module lane_queue_cell #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic             depTick,
    input  logic             green,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic dec;
    // An empty lane never departs, so it cannot underflow.
    assign dec = depTick & green & (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc & ~dec) begin
            if (count == CNT_MAX) overflow <= 1'b1;
            else                  count    <= count + 1'b1;
        end else if (dec & ~inc) begin
            count <= count - 1'b1;
        end
    end
endmodule

module lane_queue_counter #(
    parameter int NUM_LANES  = 8,
    parameter int CNT_W      = 8,
    parameter int DEPART_DIV = 4
) (
    input logic                  clk,
    input logic                  rst,
    lane_queue_counter_if.slave  bus
);
    localparam logic [7:0] DIV_LAST = 8'(DEPART_DIV - 1);

    logic [7:0]                      prescaler;
    logic                            depTick;
    logic [NUM_LANES-1:0]            arrivePulse;
    logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
    logic [NUM_LANES-1:0]            ovf;
    logic [2:0]                      nextBusy;
    logic [CNT_W-1:0]                bestVal;

    // Departure prescaler: 0..DEPART_DIV-1, tick on the last value.
    assign depTick = (prescaler == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   prescaler <= '0;
        else if (bus.clear|depTick) prescaler <= '0;
        else                        prescaler <= prescaler + 8'd1;
    end

`ifdef LANE_QUEUE_DEBOUNCE_EN
    // Raw sensor level -> 2-flop synchroniser -> rising-edge pulse.
    logic [NUM_LANES-1:0] syncA, syncB, syncPrev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncA    <= '0;
            syncB    <= '0;
            syncPrev <= '0;
        end else begin
            syncA    <= bus.arrive;
            syncB    <= syncA;
            syncPrev <= syncB;
        end
    end

    assign arrivePulse = syncB & ~syncPrev;
`else
    assign arrivePulse = bus.arrive;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : gLane
            lane_queue_cell #(.CNT_W(CNT_W)) uCell (
                .clk      (clk),
                .rst      (rst),
                .clear    (bus.clear),
                .inc      (arrivePulse[gi]),
                .depTick  (depTick),
                .green    (bus.green[gi]),
                .count    (cnt[gi]),
                .overflow (ovf[gi])
            );
        end
    endgenerate

    assign bus.laneCounts = cnt;
    assign bus.overflow   = ovf;

    // Scan upward with >= so ties land on the highest index; zero counts
    // are skipped so an empty intersection reports lane 0.
    always_comb begin
        nextBusy = '0;
        bestVal  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (cnt[i] != '0 && cnt[i] >= bestVal) begin
                bestVal  = cnt[i];
                nextBusy = 3'(i);
            end
        end
    end

    // Summary outputs trail laneCounts by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.busiestLane <= '0;
            bus.anyWaiting  <= 1'b0;
        end else begin
            bus.busiestLane <= nextBusy;
            bus.anyWaiting  <= |cnt;
        end
    end
endmodule

// File: tb/tb_lane_queue_counter.sv
module tb_lane_queue_counter;
    localparam int NL  = 8;
    localparam int CW  = 8;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lane_queue_counter_if #(.NUM_LANES(NL), .CNT_W(CW)) bus ();

    lane_queue_counter #(.NUM_LANES(NL), .CNT_W(CW), .DEPART_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: plain integer queue lengths.
    int       mCnt[NL];
    bit       mOvf[NL];
    int       mPresc;
    int       mBusy;
    bit       mAny;
    bit [NL-1:0] h1, h2, h3; // arrive history for the debounced build

    function automatic int busiestOf();
        int best = 0;
        int idx  = 0;
        for (int i = 0; i < NL; i++) if (mCnt[i] > best) best = mCnt[i];
        if (best == 0) return 0;
        for (int i = 0; i < NL; i++) if (mCnt[i] == best) idx = i;
        return idx;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NL; i++) begin mCnt[i] = 0; mOvf[i] = 0; end
        mPresc = 0; mBusy = 0; mAny = 0;
        h1 = '0; h2 = '0; h3 = '0;
    endtask

    task automatic modelEdge(input bit [NL-1:0] a, input bit [NL-1:0] g, input bit c);
        bit [NL-1:0] eff;
        bit tick;
        int anySum = 0;
`ifdef LANE_QUEUE_DEBOUNCE_EN
        eff = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = a;
`else
        eff = a;
`endif
        // summary outputs see the counts from before this edge
        mBusy = busiestOf();
        for (int i = 0; i < NL; i++) anySum += mCnt[i];
        mAny = (anySum != 0);
        tick = (mPresc == DIV - 1);
        if (c) begin
            for (int i = 0; i < NL; i++) begin mCnt[i] = 0; mOvf[i] = 0; end
            mPresc = 0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                bit up = eff[i];
                bit dn = tick && g[i] && mCnt[i] > 0;
                if (up && !dn) begin
                    if (mCnt[i] == 255) mOvf[i] = 1;
                    else mCnt[i]++;
                end else if (dn && !up) mCnt[i]--;
            end
            mPresc = tick ? 0 : mPresc + 1;
        end
    endtask

    task automatic checkAll(input string tag);
        logic [NL*CW-1:0] expCnt;
        logic [NL-1:0]    expOvf;
        for (int i = 0; i < NL; i++) begin
            expCnt[i*CW +: CW] = CW'(mCnt[i]);
            expOvf[i] = mOvf[i];
        end
        vectors++;
        if (bus.laneCounts !== expCnt) begin
            errors++;
            $display("FAIL %s laneCounts got %h exp %h", tag, bus.laneCounts, expCnt);
        end
        vectors++;
        if (bus.overflow !== expOvf) begin
            errors++;
            $display("FAIL %s overflow got %b exp %b", tag, bus.overflow, expOvf);
        end
        vectors++;
        if (bus.busiestLane !== 3'(mBusy)) begin
            errors++;
            $display("FAIL %s busiestLane got %0d exp %0d", tag, bus.busiestLane, mBusy);
        end
        vectors++;
        if (bus.anyWaiting !== mAny) begin
            errors++;
            $display("FAIL %s anyWaiting got %b exp %b", tag, bus.anyWaiting, mAny);
        end
    endtask

    task automatic step(input bit [NL-1:0] a, input bit [NL-1:0] g, input bit c, input string tag);
        @(negedge clk);
        bus.arrive = a; bus.green = g; bus.clear = c;
        @(posedge clk);
        modelEdge(a, g, c);
        #1;
        checkAll(tag);
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.laneCounts !== '0 || bus.overflow !== '0 || bus.busiestLane !== 3'd0 || bus.anyWaiting !== 1'b0) begin
            errors++;
            $display("FAIL reset got cnt=%h ovf=%b busy=%0d any=%b exp all 0",
                     bus.laneCounts, bus.overflow, bus.busiestLane, bus.anyWaiting);
        end
        for (int i = 0; i < 20; i++) step('0, '0, 1'b0, "idle");
    endtask

    task automatic test_arrival();
        for (int i = 0; i < 5; i++) step(8'h40, '0, 1'b0, "arrive_w2");
        for (int i = 0; i < 4; i++) step('0, '0, 1'b0, "arrive_w2_settle");
        vectors++;
        if (bus.busiestLane !== 3'd6 || bus.anyWaiting !== 1'b1) begin
            errors++;
            $display("FAIL arrive_w2_busy got %0d/%b exp 6/1", bus.busiestLane, bus.anyWaiting);
        end
    endtask

    task automatic test_departure();
        step('0, '0, 1'b1, "dep_clear");
        for (int i = 0; i < 3; i++) begin
            step(8'h01, '0, 1'b0, "dep_load");
            step('0, '0, 1'b0, "dep_load");
        end
        for (int i = 0; i < 4; i++) step('0, '0, 1'b0, "dep_load_settle");
        for (int i = 0; i < 24; i++) step('0, 8'h01, 1'b0, "dep_drain");
        vectors++;
        if (bus.laneCounts[CW-1:0] !== 8'd0 || bus.anyWaiting !== 1'b0) begin
            errors++;
            $display("FAIL dep_empty got %0d/%b exp 0/0", bus.laneCounts[CW-1:0], bus.anyWaiting);
        end
    endtask

    task automatic test_saturation();
        step('0, '0, 1'b1, "sat_clear");
        for (int i = 0; i < 256; i++) begin
            step(8'h80, '0, 1'b0, "sat_fill");
            step('0, '0, 1'b0, "sat_fill");
        end
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, "sat_settle");
        vectors++;
        if (bus.laneCounts[7*CW +: CW] !== 8'd255 || bus.overflow[7] !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got %0d/%b exp 255/1", bus.laneCounts[7*CW +: CW], bus.overflow[7]);
        end
        for (int i = 0; i < 2*DIV; i++) step(8'h80, 8'h80, 1'b0, "sat_arrive_depart");
        step(8'hFF, 8'hFF, 1'b1, "sat_clear_prio");
        vectors++;
        if (bus.laneCounts !== '0 || bus.overflow !== '0) begin
            errors++;
            $display("FAIL sat_cleared got %h/%b exp 0/0", bus.laneCounts, bus.overflow);
        end
    endtask

    task automatic test_tie();
        step('0, '0, 1'b1, "tie_clear");
        for (int i = 0; i < 7; i++) begin
            step(8'h24, '0, 1'b0, "tie_load");
            step('0, '0, 1'b0, "tie_load");
        end
        for (int i = 0; i < 4; i++) step('0, '0, 1'b0, "tie_settle");
        vectors++;
        if (bus.busiestLane !== 3'd5) begin
            errors++;
            $display("FAIL tie_busiest got %0d exp 5", bus.busiestLane);
        end
    endtask

    task automatic test_random();
        step('0, '0, 1'b1, "rnd_clear");
        for (int i = 0; i < 400; i++) begin
            bit [NL-1:0] a = NL'($urandom);
            bit [NL-1:0] g = NL'($urandom) & NL'($urandom);
            bit c = ($urandom_range(0, 63) == 0);
            step(a, g, c, "random");
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) step(8'hA5, '0, 1'b0, "arst_load");
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        modelReset();
        vectors++;
        if (bus.laneCounts !== '0 || bus.overflow !== '0 || bus.busiestLane !== 3'd0 || bus.anyWaiting !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got cnt=%h ovf=%b busy=%0d any=%b exp all 0",
                     bus.laneCounts, bus.overflow, bus.busiestLane, bus.anyWaiting);
        end
        bus.arrive = '0; bus.green = '0; bus.clear = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step('0, '0, 1'b0, "post_reset");
    endtask

`ifdef LANE_QUEUE_DEBOUNCE_EN
    task automatic test_debounce();
        step('0, '0, 1'b1, "db_clear");
        for (int i = 0; i < 10; i++) step(8'h02, '0, 1'b0, "db_held");
        for (int i = 0; i < 4; i++) step('0, '0, 1'b0, "db_settle");
        vectors++;
        if (bus.laneCounts[1*CW +: CW] !== 8'd1) begin
            errors++;
            $display("FAIL db_one_car got %0d exp 1", bus.laneCounts[1*CW +: CW]);
        end
    endtask
`endif

    initial begin
        bus.arrive = '0; bus.green = '0; bus.clear = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_arrival();
        test_departure();
        test_saturation();
        test_tie();
`ifdef LANE_QUEUE_DEBOUNCE_EN
        test_debounce();
`endif
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
